// File: rtl/wallace_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : wallace_pkg                                               |
// | Description : Shared constants, types and sizing helpers for the        |
// |               Wallace-tree multiplier datapath.                         |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
package wallace_pkg;

  // Register stages between operand acceptance and product presentation
  localparam int c_stages = 3;

  // Widest operand the datapath is sized for
  localparam int c_w_max = 16;

  // One partial-product row spans the full 2W-bit product
  typedef logic [2*c_w_max-1:0] pp_row_t;

  // W partial-product rows plus one spare row for the signed-mode constants
  typedef pp_row_t [c_w_max:0] pp_array_t;

  // Redundant (carry-save) form of the product leaving the reduction tree
  typedef struct packed {
    pp_row_t sum;
    pp_row_t carry;
  } csa_pair_t;

  // Rows left after one layer: each triple becomes a sum/carry pair, leftovers stay
  function automatic int csa_rows_out(input int rows);
    return (rows > 2) ? (2 * (rows / 3) + (rows % 3)) : rows;
  endfunction

  // Rows left after a given number of reduction layers
  function automatic int rows_after(input int rows, input int layers);
    int h;
    h = rows;
    for (int k = 0; k < layers; k++) begin
      h = csa_rows_out(h);
    end
    return h;
  endfunction

  // Number of carry-save layers needed to bring the tree height down to two
  function automatic int wallace_layers(input int rows);
    int h;
    int n;
    h = rows;
    n = 0;
    for (int k = 0; k < 32; k++) begin
      if (h > 2) begin
        h = csa_rows_out(h);
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wallace_mult_pipe_csa_layer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : full_adder / half_adder / csa_layer                       |
// | Description : Adder cells and one carry-save reduction layer. Rows are  |
// |               taken three at a time through full adders; a leftover    |
// |               pair goes through half adders, a single row passes.      |
// |               Carries out of the top column fall off: the datapath is   |
// |               modulo 2^WIDTH and the final product fits in WIDTH bits. |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module csa_layer
  import wallace_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_IN  = 3,
  localparam int N_OUT = csa_rows_out(N_IN)
) (
  input  logic [N_IN-1:0][WIDTH-1:0]  rows_in,
  output logic [N_OUT-1:0][WIDTH-1:0] rows_out
);

  localparam int c_groups = N_IN / 3;
  localparam int c_rem    = N_IN % 3;

  // Each row triple is compressed column-wise into a sum row and a shifted carry row
  for (genvar g = 0; g < c_groups; g++) begin : g_grp
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-2:0] w_c;
    for (genvar j = 0; j < WIDTH-1; j++) begin : g_bit
      full_adder u_fa (
        .a  (rows_in[3*g][j]),
        .b  (rows_in[3*g+1][j]),
        .ci (rows_in[3*g+2][j]),
        .s  (w_s[j]),
        .co (w_c[j])
      );
    end
    assign w_s[WIDTH-1]    = rows_in[3*g][WIDTH-1] ^ rows_in[3*g+1][WIDTH-1] ^ rows_in[3*g+2][WIDTH-1];
    assign rows_out[2*g]   = w_s;
    assign rows_out[2*g+1] = {w_c, 1'b0};
  end

  // A leftover pair is half-added; a single leftover row is forwarded untouched
  if (c_rem == 2) begin : g_ha
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-2:0] w_c;
    for (genvar j = 0; j < WIDTH-1; j++) begin : g_bit
      half_adder u_ha (
        .a  (rows_in[N_IN-2][j]),
        .b  (rows_in[N_IN-1][j]),
        .s  (w_s[j]),
        .co (w_c[j])
      );
    end
    assign w_s[WIDTH-1]             = rows_in[N_IN-2][WIDTH-1] ^ rows_in[N_IN-1][WIDTH-1];
    assign rows_out[2*c_groups]     = w_s;
    assign rows_out[2*c_groups + 1] = {w_c, 1'b0};
  end else if (c_rem == 1) begin : g_pass
    assign rows_out[2*c_groups] = rows_in[N_IN-1];
  end

endmodule
`default_nettype wire

// File: rtl/wallace_mult_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : wallace_mult_pipe                                         |
// | Description : Elastic three-stage W x W multiplier.                     |
// |               S1 = partial-product rows, S2 = carry-save pair after a   |
// |               Wallace tree, S3 = product from a ripple adder.           |
// |               Define WALLACE_SIGNED_EN for two's-complement operands    |
// |               (Baugh-Wooley partial products plus a constant row).     |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p
);

  localparam int c_pw = 2 * W;
`ifdef WALLACE_SIGNED_EN
  localparam int c_rows = W + 1;
`else
  localparam int c_rows = W;
`endif
  localparam int c_layers = wallace_layers(c_rows);

  logic [c_stages-1:0]          r_valid;
  logic                         w_s1_adv;
  logic                         w_s2_adv;
  logic                         w_s3_adv;
  logic [c_rows-1:0][c_pw-1:0]  w_pp;
  logic [c_rows-1:0][c_pw-1:0]  r_s1_rows;
  logic [c_pw-1:0]              w_tree_sum;
  logic [c_pw-1:0]              w_tree_carry;
  logic [c_pw-1:0]              r_s2_sum;
  logic [c_pw-1:0]              r_s2_carry;
  logic [c_pw-1:0]              w_cpa_sum;
  logic [c_pw-1:0]              w_cpa_c;
  logic [c_pw-1:0]              r_s3_prod;

  // A stage moves when it is empty or its successor moves; the last one moves on out_ready
  assign w_s3_adv  = !r_valid[2] || out_ready;
  assign w_s2_adv  = !r_valid[1] || w_s3_adv;
  assign w_s1_adv  = !r_valid[0] || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_valid[2];
  assign out_p     = r_s3_prod;

  // Partial-product rows, each placed at its column offset
  for (genvar i = 0; i < W; i++) begin : g_pp
    logic [W-1:0] w_bits;
`ifdef WALLACE_SIGNED_EN
    // Bits pairing exactly one operand MSB carry negative weight and are complemented
    localparam logic [W-1:0] c_inv = (i == W-1) ? {1'b0, {(W-1){1'b1}}}
                                                : {1'b1, {(W-1){1'b0}}};
    assign w_bits = (in_a & {W{in_b[i]}}) ^ c_inv;
`else
    assign w_bits = in_a & {W{in_b[i]}};
`endif
    assign w_pp[i] = {{W{1'b0}}, w_bits} << i;
  end

`ifdef WALLACE_SIGNED_EN
  // Correction constants for the complemented bits: +2^W and +2^(2W-1)
  localparam logic [c_pw-1:0] c_bw_const = (c_pw'(1) << W) | (c_pw'(1) << (c_pw-1));
  assign w_pp[W] = c_bw_const;
`endif

  // Wallace tree: one carry-save layer per generate iteration until two rows remain
  for (genvar l = 0; l < c_layers; l++) begin : g_layer
    localparam int c_n_in  = rows_after(c_rows, l);
    localparam int c_n_out = rows_after(c_rows, l + 1);
    logic [c_n_in-1:0][c_pw-1:0]  w_in;
    logic [c_n_out-1:0][c_pw-1:0] w_out;
    if (l == 0) begin : g_first
      assign w_in = r_s1_rows;
    end else begin : g_next
      assign w_in = g_layer[l-1].w_out;
    end
    csa_layer #(
      .WIDTH (c_pw),
      .N_IN  (c_n_in)
    ) u_csa (
      .rows_in  (w_in),
      .rows_out (w_out)
    );
  end

  assign w_tree_sum   = g_layer[c_layers-1].w_out[0];
  assign w_tree_carry = g_layer[c_layers-1].w_out[1];

  // Ripple carry-propagate adder resolving the carry-save pair held in S2
  assign w_cpa_c[0] = 1'b0;
  for (genvar j = 0; j < c_pw-1; j++) begin : g_cpa
    full_adder u_fa (
      .a  (r_s2_sum[j]),
      .b  (r_s2_carry[j]),
      .ci (w_cpa_c[j]),
      .s  (w_cpa_sum[j]),
      .co (w_cpa_c[j+1])
    );
  end
  assign w_cpa_sum[c_pw-1] = r_s2_sum[c_pw-1] ^ r_s2_carry[c_pw-1] ^ w_cpa_c[c_pw-1];

  // Stage registers: valid bits follow the advance chain, data loads only behind a valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_s1_rows  <= '0;
      r_s2_sum   <= '0;
      r_s2_carry <= '0;
      r_s3_prod  <= '0;
    end else begin
      if (w_s1_adv) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_s1_rows <= w_pp;
        end
      end
      if (w_s2_adv) begin
        r_valid[1] <= r_valid[0];
        if (r_valid[0]) begin
          r_s2_sum   <= w_tree_sum;
          r_s2_carry <= w_tree_carry;
        end
      end
      if (w_s3_adv) begin
        r_valid[2] <= r_valid[1];
        if (r_valid[1]) begin
          r_s3_prod <= w_cpa_sum;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wallace_mult_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : tb_wallace_mult_pipe                                      |
// | Description : Self-checking bench for wallace_mult_pipe (W=8). Follows  |
// |               WALLACE_SIGNED_EN for the arithmetic reference.           |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module tb_wallace_mult_pipe;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_p;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int n_acc       = 0;

  // Products in flight, oldest first, tagged with the clock edge that captured them
  typedef struct {
    logic [PW-1:0] prod;
    int            acc_edge;
  } item_t;
  item_t q[$];

  wallace_mult_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: plain integer multiply of the operands as numbers
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint pa;
    longint pb;
    longint p;
`ifdef WALLACE_SIGNED_EN
    pa = longint'($signed(a));
    pb = longint'($signed(b));
`else
    pa = longint'(a);
    pb = longint'(b);
`endif
    p = pa * pb;
    return p[PW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check handshake/outputs against the queue model, clock, update model
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
    logic  exp_rdy;
    logic  exp_ov;
    logic  acc;
    logic  emit;
    item_t it;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    exp_rdy = !((q.size() == 3) && !ordy);
    exp_ov  = (q.size() != 0) && ((cyc - q[0].acc_edge) >= 2);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) chk("out_p", 32'(out_p), 32'(q[0].prod));
    acc  = v && exp_rdy;
    emit = exp_ov && ordy;
    @(posedge clk);
    cyc++;
    if (emit) void'(q.pop_front());
    if (acc) begin
      it.prod     = ref_mul(a, b);
      it.acc_edge = cyc;
      q.push_back(it);
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic v);
    rst       = 1'b1;
    in_valid  = v;
    in_a      = W'($urandom);
    in_b      = W'($urandom);
    out_ready = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    q.delete();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Single isolated transfer, product checked against a literal three cycles later
  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [PW-1:0] lit);
    cycle(1'b1, a, b, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_p"}, 32'(out_p), 32'(lit));
  endtask

  initial begin
    int start;
    int guard;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    @(negedge clk);
    do_reset(1'b0);

    // Directed single transfers
`ifdef WALLACE_SIGNED_EN
    directed("m128xm128", 8'h80, 8'h80, 16'h4000);
    directed("m1x1", 8'hFF, 8'h01, 16'hFFFF);
    directed("127xm128", 8'h7F, 8'h80, 16'hC080);
`else
    directed("ffxff", 8'hFF, 8'hFF, 16'hFE01);
`endif
    directed("0xa5", 8'h00, 8'hA5, 16'h0000);
    cycle(1'b0, '0, '0, 1'b1);

    // Backpressure: fill three stages, stall five cycles, then drain
    for (int i = 0; i < 3; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      cycle(1'b1, W'($urandom), W'($urandom), 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Reset with two products in flight and a pending transfer
    cycle(1'b1, W'($urandom), W'($urandom), 1'b1);
    cycle(1'b1, W'($urandom), W'($urandom), 1'b1);
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1);

    // Full-rate streaming
    for (int i = 0; i < 256; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'b1);

    // Random gaps on in_valid and stalls on out_ready
    start = n_acc;
    guard = 0;
    while ((n_acc - start) < 1000 && guard < 20000) begin
      cycle($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), $urandom_range(0, 2) != 0);
      guard++;
    end
    chk("random_accepts", 32'(n_acc - start), 32'd1000);
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      cycle(1'b0, '0, '0, 1'b1);
      guard++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
